// File: rtl/mac_sequencer_if.sv
// Operand-pair stream into the MAC sequencer.
// Master drives valid/a/b; the sequencer (slave) drives ready.
interface mac_sequencer_if;
  logic       valid;
  logic       ready;
  logic [7:0] a;
  logic [7:0] b;

  modport master (
    output valid,
    output a,
    output b,
    input  ready
  );

  modport slave (
    input  valid,
    input  a,
    input  b,
    output ready
  );
endinterface

// File: rtl/mac_sequencer.sv
// Q1.7 dot-product sequencer driving the shared 8-bit ALU.
// Each pair is multiplied, then added into acc; done pulses at the end.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MUL = 3'd5
  } aluFunc_t;
endpackage

module mac_sequencer
  import alu_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  mac_sequencer_if.slave     pairs,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output aluFunc_t           alu_func,
  input  logic [7:0]         alu_result,
  output logic               busy,
  output logic               done,
  output logic [7:0]         acc_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    MUL     = 3'd2,
    ADD     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       acc;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [7:0]       prod;
  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic             last;

  assign accept = (state == WAIT_IN) && pairs.valid;
  assign last   = (remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (accept) begin
          state_nxt = MUL;
        end
      end
      MUL:     state_nxt = ADD;
      ADD:     state_nxt = last ? DONE : WAIT_IN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operands are pure decodes of state and registers.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_func    = ALU_ADD;
    pairs.ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      WAIT_IN: pairs.ready = 1'b1;
      MUL: begin
        alu_a    = op_a;
        alu_b    = op_b;
        alu_func = ALU_MUL;
      end
      ADD: begin
        alu_a    = acc;
        alu_b    = prod;
        alu_func = ALU_ADD;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      acc       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      prod      <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            remaining <= len;
          end
        end
        WAIT_IN: begin
          if (accept) begin
            op_a <= pairs.a;
            op_b <= pairs.b;
          end
        end
        MUL: prod <= alu_result;
        ADD: begin
          acc       <= alu_result;
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural Q1.7 ALU.
// Each scenario task drives stimulus and checks its own results.
module tb_mac_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       nReset;
  logic       start;
  logic [3:0] len;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  aluFunc_t   alu_func;
  logic [7:0] alu_result;
  logic       busy;
  logic       done;
  logic [7:0] acc_out;

  int tests;
  int fails;

  mac_sequencer_if pif ();

  mac_sequencer #(.LEN_W(4)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .start      (start),
    .len        (len),
    .pairs      (pif),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .acc_out    (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: Q1.7 multiply keeps product bits [14:7]; add wraps.
  logic signed [15:0] full;
  always_comb begin
    full       = $signed(alu_a) * $signed(alu_b);
    alu_result = alu_a + alu_b;
    if (alu_func == ALU_MUL) alu_result = full[14:7];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one dot product; observation c is the cycle after edge E+c.
  task automatic do_run(
    input  int         n,
    input  logic [7:0] av [4],
    input  logic [7:0] bv [4],
    input  int         stall_idx,
    input  int         stall_n,
    input  bit         poke_start,
    output logic [7:0] acc,
    output int         rdy,
    output int         dn,
    output int         muls,
    output int         lat,
    output bit         tmo
  );
    int k;
    int gap;
    int c;
    int dn_c;
    bit poked;
    k = 0; gap = 0; rdy = 0; dn = 0; muls = 0;
    lat = -1; acc = 'x; tmo = 1'b1; dn_c = -1; poked = 1'b0;
    start = 1'b1;
    len   = 4'(n);
    pif.valid = 1'b0;
    tick();
    start = 1'b0;
    for (c = 0; c < 200; c++) begin
      start     = 1'b0;
      pif.valid = 1'b0;
      if (pif.ready) begin
        rdy++;
        if (k == stall_idx && gap < stall_n) begin
          gap++;
        end else if (k < 4) begin
          pif.valid = 1'b1;
          pif.a     = av[k];
          pif.b     = bv[k];
          k++;
        end
      end
      if (alu_func == ALU_MUL) begin
        muls++;
        if (poke_start && !poked) begin
          start = 1'b1;
          len   = 4'd1;
          poked = 1'b1;
        end
      end
      if (done) begin
        dn++;
        if (dn == 1) begin
          acc  = acc_out;
          lat  = c;
          dn_c = c;
        end
      end
      if (dn_c >= 0 && c >= dn_c + 4) begin
        tmo = 1'b0;
        break;
      end
      tick();
    end
    start     = 1'b0;
    pif.valid = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    start  = 1'b0;
    len    = '0;
    pif.valid = 1'b0;
    pif.a  = '0;
    pif.b  = '0;
    tick();
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done got %b want 0", done);
    end
    tests++;
    if (pif.ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got %b want 0", pif.ready);
    end
    tests++;
    if (acc_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_acc got %h want 00", acc_out);
    end
    tests++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_func !== ALU_ADD) begin
      fails++;
      $display("FAIL reset_alu got %h %h %0d want 00 00 %0d",
               alu_a, alu_b, alu_func, ALU_ADD);
    end
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    start = 1'b1;
    len   = 4'd1;
    pif.valid = 1'b1;
    pif.a = 8'h40;
    pif.b = 8'h40;
    tick();
    start = 1'b0;
    tests++;
    if (pif.ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL t1_wait got rdy=%b busy=%b want 1 1", pif.ready, busy);
    end
    tick();
    pif.valid = 1'b0;
    tests++;
    if (alu_func !== ALU_MUL || alu_a !== 8'h40 || alu_b !== 8'h40) begin
      fails++;
      $display("FAIL t1_mul got %0d %h %h want %0d 40 40",
               alu_func, alu_a, alu_b, ALU_MUL);
    end
    tick();
    tests++;
    if (alu_func !== ALU_ADD || alu_a !== 8'h00 || alu_b !== 8'h20) begin
      fails++;
      $display("FAIL t1_add got %0d %h %h want %0d 00 20",
               alu_func, alu_a, alu_b, ALU_ADD);
    end
    tick();
    tests++;
    if (done !== 1'b1 || acc_out !== 8'h20) begin
      fails++;
      $display("FAIL t1_done got done=%b acc=%h want 1 20", done, acc_out);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || acc_out !== 8'h20) begin
      fails++;
      $display("FAIL t1_idle got done=%b busy=%b acc=%h want 0 0 20",
               done, busy, acc_out);
    end
  endtask

  task automatic test_multi();
    logic [7:0] av [4] = '{8'h40, 8'h40, 8'h40, 8'h00};
    logic [7:0] bv [4] = '{8'h40, 8'h40, 8'h40, 8'h00};
    logic [7:0] acc;
    int rdy, dn, muls, lat;
    bit tmo;
    do_run(3, av, bv, -1, 0, 1'b0, acc, rdy, dn, muls, lat, tmo);
    tests++;
    if (tmo || acc !== 8'h60) begin
      fails++;
      $display("FAIL t2_acc got %h tmo=%b want 60", acc, tmo);
    end
    tests++;
    if (rdy != 3) begin
      fails++;
      $display("FAIL t2_ready got %0d want 3", rdy);
    end
    tests++;
    if (dn != 1 || lat != 9) begin
      fails++;
      $display("FAIL t2_done got n=%0d lat=%0d want 1 9", dn, lat);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] av [4] = '{8'h40, 8'hC0, 8'h00, 8'h00};
    logic [7:0] bv [4] = '{8'h40, 8'h40, 8'h00, 8'h00};
    logic [7:0] acc;
    int rdy, dn, muls, lat;
    bit tmo;
    do_run(2, av, bv, -1, 0, 1'b0, acc, rdy, dn, muls, lat, tmo);
    tests++;
    if (tmo || acc !== 8'h00) begin
      fails++;
      $display("FAIL t3_wrap got %h tmo=%b want 00", acc, tmo);
    end
    tests++;
    if (muls != 2 || lat != 6) begin
      fails++;
      $display("FAIL t3_seq got muls=%0d lat=%0d want 2 6", muls, lat);
    end
  endtask

  task automatic test_len0();
    logic [7:0] av [4] = '{8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] bv [4] = '{8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] acc;
    int rdy, dn, muls, lat;
    bit tmo;
    do_run(0, av, bv, -1, 0, 1'b0, acc, rdy, dn, muls, lat, tmo);
    tests++;
    if (tmo || acc !== 8'h00) begin
      fails++;
      $display("FAIL t4_acc got %h tmo=%b want 00", acc, tmo);
    end
    tests++;
    if (rdy != 0 || muls != 0) begin
      fails++;
      $display("FAIL t4_quiet got rdy=%0d muls=%0d want 0 0", rdy, muls);
    end
    tests++;
    if (dn != 1 || lat != 0) begin
      fails++;
      $display("FAIL t4_done got n=%0d lat=%0d want 1 0", dn, lat);
    end
  endtask

  task automatic test_stall();
    logic [7:0] av [4] = '{8'h40, 8'h20, 8'h00, 8'h00};
    logic [7:0] bv [4] = '{8'h40, 8'h40, 8'h00, 8'h00};
    logic [7:0] acc;
    int rdy, dn, muls, lat;
    bit tmo;
    do_run(2, av, bv, 1, 5, 1'b1, acc, rdy, dn, muls, lat, tmo);
    tests++;
    if (tmo || acc !== 8'h30) begin
      fails++;
      $display("FAIL t5_acc got %h tmo=%b want 30", acc, tmo);
    end
    tests++;
    if (rdy != 7) begin
      fails++;
      $display("FAIL t5_ready got %0d want 7", rdy);
    end
    tests++;
    if (dn != 1 || lat != 11 || muls != 2) begin
      fails++;
      $display("FAIL t5_done got n=%0d lat=%0d muls=%0d want 1 11 2",
               dn, lat, muls);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL t5_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] av [4] = '{8'h40, 8'h20, 8'h00, 8'h00};
    logic [7:0] bv [4] = '{8'h40, 8'h40, 8'h00, 8'h00};
    logic [7:0] acc;
    int rdy, dn, muls, lat;
    bit tmo;
    bit seen;
    int dseen;
    seen = 1'b0;
    start = 1'b1;
    len   = 4'd3;
    pif.valid = 1'b1;
    pif.a = 8'h40;
    pif.b = 8'h40;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy && alu_func == ALU_ADD && alu_b == 8'h20) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL t6_add got no ADD cycle want one within 20");
    end
    nReset = 1'b0;
    pif.valid = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pif.ready !== 1'b0) begin
      fails++;
      $display("FAIL t6_ctl got busy=%b done=%b rdy=%b want 0 0 0",
               busy, done, pif.ready);
    end
    tests++;
    if (acc_out !== 8'h00 || alu_a !== 8'h00 || alu_b !== 8'h00 ||
        alu_func !== ALU_ADD) begin
      fails++;
      $display("FAIL t6_data got acc=%h a=%h b=%h f=%0d want 00 00 00 %0d",
               acc_out, alu_a, alu_b, alu_func, ALU_ADD);
    end
    nReset = 1'b1;
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dseen++;
      tick();
    end
    tests++;
    if (dseen != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t6_nodone got dones=%0d busy=%b want 0 0", dseen, busy);
    end
    do_run(1, av, bv, -1, 0, 1'b0, acc, rdy, dn, muls, lat, tmo);
    tests++;
    if (tmo || acc !== 8'h20 || dn != 1 || lat != 3) begin
      fails++;
      $display("FAIL t6_rerun got acc=%h n=%0d lat=%0d want 20 1 3",
               acc, dn, lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_multi();
    test_wrap();
    test_len0();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
